// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_AW = 12;
    localparam int DMEM_DW = 32;

    // Requester IDs double as bit positions in the request/grant vectors
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        LOCKED_CPU = 2'd1,
        LOCKED_AUX = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie, the requester not granted most recently wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && (!req[REQ_AUX] || (last == REQ_AUX))) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_AUX]) begin
            gnt[REQ_AUX] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port dmem between the CPU and an auxiliary port, with
// bus locking and a fixed one-cycle read return tagged to the granted requester.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   FREE       | no lock held; round-robin between requesters
//   LOCKED_CPU | CPU holds the bus; only CPU requests are granted
//   LOCKED_AUX | AUX holds the bus; only AUX requests are granted
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          aux_req,
    input  logic          aux_we,
    input  logic          aux_lock,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,

    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    arb_state_e state_q, state_d;
    logic       last_q;
    logic       cpu_pend_q, aux_pend_q;
    logic [1:0] pick;

    rr_pick2 u_pick (
        .req  ({aux_req, cpu_req}),
        .last (last_q),
        .gnt  (pick)
    );

    // Grants are gated by reset so nothing reaches the memory while in reset
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        state_d = state_q;
        if (!reset) begin
            case (state_q)
                FREE: begin
                    cpu_gnt = pick[REQ_CPU];
                    aux_gnt = pick[REQ_AUX];
                    if (cpu_gnt && cpu_lock) begin
                        state_d = LOCKED_CPU;
                    end else if (aux_gnt && aux_lock) begin
                        state_d = LOCKED_AUX;
                    end
                end
                LOCKED_CPU: begin
                    cpu_gnt = cpu_req;
                    if (!cpu_lock && (cpu_gnt || !cpu_req)) begin
                        state_d = FREE;
                    end
                end
                LOCKED_AUX: begin
                    aux_gnt = aux_req;
                    if (!aux_lock && (aux_gnt || !aux_req)) begin
                        state_d = FREE;
                    end
                end
                default: state_d = FREE;
            endcase
        end
    end

    always_comb begin
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        if (cpu_gnt) begin
            mem_wren    = cpu_we;
            mem_address = cpu_addr;
            mem_data    = cpu_wdata;
        end else if (aux_gnt) begin
            mem_wren    = aux_we;
            mem_address = aux_addr;
            mem_data    = aux_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FREE;
            last_q     <= REQ_AUX;
            cpu_pend_q <= 1'b0;
            aux_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (cpu_gnt) begin
                last_q <= REQ_CPU;
            end else if (aux_gnt) begin
                last_q <= REQ_AUX;
            end
            cpu_pend_q <= cpu_gnt && !cpu_we;
            aux_pend_q <= aux_gnt && !aux_we;
        end
    end

    // mem_q belongs to whichever requester had a read granted last cycle
    assign cpu_rvalid = cpu_pend_q;
    assign aux_rvalid = aux_pend_q;
    assign cpu_rdata  = cpu_pend_q ? mem_q : '0;
    assign aux_rdata  = aux_pend_q ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed grant sequences, memory-side
// checks each cycle, and read returns matched against queued expectations.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 0, cpu_we = 0, cpu_lock = 0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          aux_req = 0, aux_we = 0, aux_lock = 0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, mem_wren;
    logic [DW-1:0] cpu_rdata, aux_rdata, mem_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_q = '0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          cpu_q[$];
    exp_t          aux_q[$];
    logic [DW-1:0] sram   [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            obs_cpu = 0;
    int            obs_aux = 0;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-before-write
    always @(posedge clock) begin
        mem_q <= sram[mem_address];
        if (mem_wren) sram[mem_address] = mem_data;
    end

    function automatic logic [DW-1:0] pattern(input int a);
        return 32'hC0DE_0000 | (a & 32'hFFFF);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One arbitration cycle with the inputs already driven
    task automatic tick(input logic ecg, input logic eag);
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        exp_t          e;
        @(negedge clock);
        check("cpu_gnt", cpu_gnt, ecg);
        check("aux_gnt", aux_gnt, eag);
        ew = 1'b0; ea = '0; ed = '0;
        if (ecg) begin
            ew = cpu_we; ea = cpu_addr; ed = cpu_wdata;
        end else if (eag) begin
            ew = aux_we; ea = aux_addr; ed = aux_wdata;
        end
        check("mem_wren", mem_wren, ew);
        check("mem_address", mem_address, ea);
        check("mem_data", mem_data, ed);
        if (ecg && !cpu_we) begin
            e.cyc = cyc + 1; e.data = shadow[cpu_addr]; cpu_q.push_back(e);
        end
        if (eag && !aux_we) begin
            e.cyc = cyc + 1; e.data = shadow[aux_addr]; aux_q.push_back(e);
        end
        if (ecg && cpu_we) shadow[cpu_addr] = cpu_wdata;
        if (eag && aux_we) shadow[aux_addr] = aux_wdata;
        if (cpu_gnt) obs_cpu++;
        if (aux_gnt) obs_aux++;
        @(posedge clock);
        #1;
    endtask

    // Read-return monitor: rvalid exactly in the scheduled cycle, else idle zeros
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                check("cpu_rvalid", cpu_rvalid, 1'b1);
                check("cpu_rdata", cpu_rdata, cpu_q[0].data);
                void'(cpu_q.pop_front());
            end else begin
                check("cpu_rvalid_idle", cpu_rvalid, 1'b0);
                check("cpu_rdata_idle", cpu_rdata, '0);
            end
            if (aux_q.size() > 0 && aux_q[0].cyc == cyc) begin
                check("aux_rvalid", aux_rvalid, 1'b1);
                check("aux_rdata", aux_rdata, aux_q[0].data);
                void'(aux_q.pop_front());
            end else begin
                check("aux_rvalid_idle", aux_rvalid, 1'b0);
                check("aux_rdata_idle", aux_rdata, '0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]   = pattern(i);
            shadow[i] = pattern(i);
        end

        // Reset holds every output quiet even with requests present
        repeat (2) @(posedge clock);
        #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0AA; cpu_wdata = 32'h5555_AAAA;
        aux_req = 1; aux_addr = 12'h0BB;
        @(negedge clock);
        check("rst_cpu_gnt", cpu_gnt, 1'b0);
        check("rst_aux_gnt", aux_gnt, 1'b0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_mem_address", mem_address, '0);
        check("rst_mem_data", mem_data, '0);
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_aux_rvalid", aux_rvalid, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, '0);
        @(posedge clock);
        #1;

        // Tie after reset: CPU first, then AUX, reads return one cycle later
        reset = 0;
        cpu_we = 0; cpu_addr = 12'h010; aux_we = 0; aux_addr = 12'h020;
        tick(1, 0);
        cpu_req = 0;
        tick(0, 1);
        aux_req = 0;
        tick(0, 0);

        // Eight cycles of dual requests alternate strictly
        obs_cpu = 0; obs_aux = 0;
        begin
            int cn = 0, an = 0;
            for (int i = 0; i < 8; i++) begin
                cpu_req = 1; cpu_addr = 12'h040 + 12'(cn);
                aux_req = 1; aux_addr = 12'h080 + 12'(an);
                tick((i % 2) == 0, (i % 2) == 1);
                if ((i % 2) == 0) cn++; else an++;
            end
        end
        check("rr_cpu_count", obs_cpu, 4);
        check("rr_aux_count", obs_aux, 4);
        cpu_req = 0; aux_req = 0;

        // AUX locks the bus for three writes; CPU waits until the lock drops
        cpu_req = 1; cpu_addr = 12'h030;
        tick(1, 0);
        cpu_addr = 12'h031;
        aux_req = 1; aux_we = 1; aux_lock = 1; aux_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            aux_addr = 12'h100 + 12'(i);
            tick(0, 1);
        end
        aux_req = 0; aux_we = 0; aux_lock = 0;
        tick(0, 0);
        tick(1, 0);
        cpu_addr = 12'h101;
        tick(1, 0);
        cpu_req = 0;

        // CPU write then read-back on consecutive cycles
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h005; cpu_wdata = 32'h1234_5678;
        tick(1, 0);
        cpu_we = 0;
        tick(1, 0);
        cpu_req = 0;
        tick(0, 0);

        // CPU lock survives an idle cycle with lock held, releases on unlocked grant
        cpu_req = 1; cpu_lock = 1; cpu_addr = 12'h200;
        tick(1, 0);
        cpu_req = 0;
        aux_req = 1; aux_addr = 12'h300;
        tick(0, 0);
        cpu_req = 1; cpu_lock = 0; cpu_addr = 12'h202;
        tick(1, 0);
        cpu_req = 0;
        tick(0, 1);
        aux_req = 0;
        tick(0, 0);

        // Reset lands on a granted CPU read: no rvalid, tie rule restored
        cpu_req = 1; cpu_addr = 12'h007;
        @(negedge clock);
        check("rstgnt_pre_gnt", cpu_gnt, 1'b1);
        #1 reset = 1;
        #1;
        check("rstgnt_cpu_gnt", cpu_gnt, 1'b0);
        check("rstgnt_mem_address", mem_address, '0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 0;
        cpu_addr = 12'h008; aux_req = 1; aux_addr = 12'h009;
        tick(1, 0);
        cpu_req = 0;
        tick(0, 1);
        aux_req = 0;
        tick(0, 0);

        // Idle stays quiet and unlocked
        repeat (4) tick(0, 0);
        aux_req = 1; aux_addr = 12'h00A;
        tick(0, 1);
        aux_req = 0;
        tick(0, 0);
        tick(0, 0);

        check("cpu_q_drained", cpu_q.size(), 0);
        check("aux_q_drained", aux_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, dmem word-address width.
REQ-002 SHALL have parameter DW, default 32, dmem data width.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/aux_req  in  1  access request from the processor or from the auxiliary (loader/debug) port.
REQ-006 SHALL have ports cpu_we/aux_we  in  1  write (1) or read (0).
REQ-007 SHALL have ports cpu_lock/aux_lock  in  1  keep ownership after this access.
REQ-008 SHALL have ports cpu_addr/aux_addr  in  AW  word address.
REQ-009 SHALL have ports cpu_wdata/aux_wdata  in  DW  write data.
REQ-010 SHALL have ports cpu_gnt/aux_gnt  out  1  access accepted this cycle.
REQ-011 SHALL have ports cpu_rvalid/aux_rvalid  out  1  read data valid.
REQ-012 SHALL have ports cpu_rdata/aux_rdata  out  DW  read data.
REQ-013 SHALL have ports mem_address  out  AW, mem_data  out  DW, mem_wren  out  1, mem_q  in  DW  single-port dmem interface.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt SHALL be combinational from req and arbiter state.
REQ-015 SHALL drive mem_address/mem_data/mem_wren from the granted requester in the grant cycle; with no grant, mem_wren SHALL be 0 and address/data SHALL be held at 0.
REQ-016 SHALL resolve simultaneous unlocked requests round-robin: the requester not granted most recently wins; last_grant updates only on a grant.
REQ-017 SHALL use FSM states FREE, LOCKED_CPU, LOCKED_AUX.
REQ-018 FREE -> LOCKED_x when x is granted with x_lock=1; LOCKED_x -> FREE when x is granted with x_lock=0, or when x_req=0 and x_lock=0 in a cycle.
REQ-019 In LOCKED_x only x SHALL be granted; the other requester SHALL see gnt=0 regardless of priority.
REQ-020 Read latency SHALL be exactly 1 cycle: a read granted in cycle N asserts that requester's rvalid for exactly cycle N+1, with rdata = mem_q in N+1.
REQ-021 Writes SHALL produce no rvalid; rdata SHALL be 0 whenever rvalid is 0.
REQ-022 A requester SHALL hold req, we, addr, wdata, lock stable until gnt; the arbiter SHALL not require this for correctness of other requesters.
REQ-023 Back-to-back grants SHALL be allowed every cycle (full throughput); a read in N and any access in N+1 SHALL both complete.
REQ-024 A requester with req=1 SHALL be granted within 2 cycles when the other requester holds no lock (no starvation).

Reset
REQ-025 On reset: state=FREE, last_grant=AUX (CPU wins first tie), read-pending flags cleared.
REQ-026 During reset all gnt, rvalid, mem_wren SHALL be 0, rdata/mem_address/mem_data 0.
REQ-027 A read granted in the cycle reset asserts SHALL produce no rvalid after reset.

Structure
REQ-028 Package dmem_arb_pkg SHALL hold the FSM state enum, requester ID constants (REQ_CPU=0, REQ_AUX=1) and default AW/DW.
REQ-029 Two-way round-robin priority pick SHALL be a sub-module rr_pick2 (req[1:0], last, gnt[1:0]); remainder (FSM, muxing, read-return tagging) in dmem_arbiter.

Verification
REQ-030 After reset, cpu_req=aux_req=1 reads, addr 0x010/0x020 -> cpu_gnt cycle 1, aux_gnt cycle 2, cpu_rvalid cycle 2 and aux_rvalid cycle 3 with respective mem_q.
REQ-031 Continuous dual requests for 8 cycles -> grants alternate CPU, AUX, CPU, ... ; each requester 4 grants.
REQ-032 aux_lock=1 for 3 writes 0xDEADBEEF to 0x100..0x102 while cpu_req=1 -> cpu_gnt=0 for those cycles; CPU granted the cycle after aux_lock drops.
REQ-033 CPU write 0x12345678 to 0x005 then read 0x005 next cycle -> mem_wren=1 then 0, cpu_rvalid one cycle after read grant, rdata 0x12345678.
REQ-034 Assert reset in the cycle a CPU read is granted -> cpu_rvalid stays 0; next grant follows REQ-025 tie rule.
REQ-035 Idle (no req) -> mem_wren=0, all gnt/rvalid 0, state remains FREE.
